// File: rtl/packmem_rd_cache.sv
// Single-entry bigword read cache in front of the packet memory ping-pong buffer.
// Caching is enabled by defining PACKMEM_RD_CACHE_EN; otherwise every read goes to memory.
module packmem_rd_cache #(
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned PACKMEM_DATA_WIDTH = 64,
    parameter int unsigned PLEN_WIDTH         = 32,
    parameter int unsigned BUF_IN             = 0,
    parameter int unsigned BUF_OUT            = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         word_rd_addra,
    input  logic                          rd_en,
    input  logic                          acc,
    input  logic                          rej,
    input  logic                          rdy_ack,
    output logic                          rdy,
    output logic [PACKMEM_DATA_WIDTH-1:0] bigword,
    output logic                          bigword_vld,
    output logic [PLEN_WIDTH-1:0]         byte_len,
    output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
    output logic                          mem_rd_en,
    output logic                          mem_acc,
    output logic                          mem_rej,
    output logic                          mem_rdy_ack,
    input  logic                          mem_rdy,
    input  logic [PACKMEM_DATA_WIDTH-1:0] mem_bigword,
    input  logic                          mem_bigword_vld,
    input  logic [PLEN_WIDTH-1:0]         mem_byte_len
);

    localparam int unsigned MEM_LAT = 1 + BUF_IN + BUF_OUT;

    logic               hit;
    logic               miss;
    logic [MEM_LAT-1:0] miss_pipe;
    logic               miss_out;

    assign rdy         = mem_rdy;
    assign byte_len    = mem_byte_len;
    assign mem_rd_addr = word_rd_addra;
    assign mem_acc     = acc;
    assign mem_rej     = rej;
    assign mem_rdy_ack = rdy_ack;

    assign miss      = rd_en & ~hit;
    assign mem_rd_en = miss & rst;
    assign miss_out  = miss_pipe[MEM_LAT-1];

    // The cast keeps the low MEM_LAT bits, which also covers MEM_LAT == 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_pipe <= '0;
        end else begin
            miss_pipe <= MEM_LAT'({miss_pipe, miss});
        end
    end

`ifdef PACKMEM_RD_CACHE_EN
    logic                          inval;
    logic [ADDR_WIDTH-1:0]         tag_r;
    logic                          tag_vld_r;
    logic [PACKMEM_DATA_WIDTH-1:0] data_r;
    logic [MEM_LAT-1:0]            hit_pipe;
    logic                          hit_out;

    assign inval   = acc | rej | rdy_ack;
    assign hit     = rd_en & tag_vld_r & (word_rd_addra == tag_r) & ~inval;
    assign hit_out = hit_pipe[MEM_LAT-1];

    // Tag follows the latest issued miss; a miss in a handover cycle targets the new buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_r     <= '0;
            tag_vld_r <= 1'b0;
        end else if (miss) begin
            tag_r     <= word_rd_addra;
            tag_vld_r <= 1'b1;
        end else if (inval) begin
            tag_vld_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r   <= '0;
            hit_pipe <= '0;
        end else begin
            hit_pipe <= MEM_LAT'({hit_pipe, hit});
            if (miss_out && mem_bigword_vld) begin
                data_r <= mem_bigword;
            end
        end
    end

    always_comb begin
        bigword     = '0;
        bigword_vld = hit_out | (miss_out & mem_bigword_vld);
        if (hit_out) begin
            bigword = data_r;
        end else if (miss_out) begin
            bigword = mem_bigword;
        end
    end
`else
    assign hit = 1'b0;

    always_comb begin
        bigword     = '0;
        bigword_vld = miss_out & mem_bigword_vld;
        if (miss_out) begin
            bigword = mem_bigword;
        end
    end
`endif

endmodule

// File: tb/tb_packmem_rd_cache.sv
// Randomized scoreboard bench for packmem_rd_cache with a behavioural ping-pong memory.
module tb_packmem_rd_cache;

    localparam int unsigned AW      = 10;
    localparam int unsigned DW      = 64;
    localparam int unsigned PW      = 32;
    localparam int unsigned BUF_IN  = 1;
    localparam int unsigned BUF_OUT = 1;
    localparam int          MEM_LAT = 1 + BUF_IN + BUF_OUT;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] word_rd_addra;
    logic          rd_en, acc, rej, rdy_ack;
    logic          rdy;
    logic [DW-1:0] bigword;
    logic          bigword_vld;
    logic [PW-1:0] byte_len;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_en, mem_acc, mem_rej, mem_rdy_ack;
    logic          mem_rdy;
    logic [DW-1:0] mem_bigword;
    logic          mem_bigword_vld;
    logic [PW-1:0] mem_byte_len;

    packmem_rd_cache #(
        .ADDR_WIDTH        (AW),
        .PACKMEM_DATA_WIDTH(DW),
        .PLEN_WIDTH        (PW),
        .BUF_IN            (BUF_IN),
        .BUF_OUT           (BUF_OUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .word_rd_addra  (word_rd_addra),
        .rd_en          (rd_en),
        .acc            (acc),
        .rej            (rej),
        .rdy_ack        (rdy_ack),
        .rdy            (rdy),
        .bigword        (bigword),
        .bigword_vld    (bigword_vld),
        .byte_len       (byte_len),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_acc        (mem_acc),
        .mem_rej        (mem_rej),
        .mem_rdy_ack    (mem_rdy_ack),
        .mem_rdy        (mem_rdy),
        .mem_bigword    (mem_bigword),
        .mem_bigword_vld(mem_bigword_vld),
        .mem_byte_len   (mem_byte_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Contents of the buffer generation 'gen' at word 'addr'.
    function automatic logic [63:0] mem_word(input logic [AW-1:0] addr, input int gen);
        logic [31:0] h;
        if (addr == 10'h010 && gen == 0) return 64'h0011223344556677;
        h = ({22'd0, addr} * 32'h9E3779B9) ^ gen;
        return {gen[15:0], 6'd0, addr, h};
    endfunction

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Behavioural memory: returns each read MEM_LAT cycles later, injects stray valids.
    typedef struct {
        bit          v;
        logic [63:0] d;
    } mret_t;
    mret_t line[$];
    int    mgen = 0;
    bit    mrst = 1'b1;

    initial begin
        mret_t r;
        mem_bigword_vld = 1'b0;
        mem_bigword     = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                line.delete();
                mrst = 1'b1;
            end else begin
                mrst = 1'b0;
                if (acc || rej || rdy_ack) mgen++;
                line.push_back('{mem_rd_en, mem_word(mem_rd_addr, mgen)});
            end
            @(posedge clk);
            #1;
            mem_bigword = {$urandom, $urandom};
            mem_bigword_vld = 1'b0;
            if (!mrst && line.size() > MEM_LAT - 1) begin
                r = line.pop_front();
                if (r.v) begin
                    mem_bigword_vld = 1'b1;
                    mem_bigword     = r.d;
                end else begin
                    mem_bigword_vld = ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // Monitor: every output beat must match the oldest outstanding request, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("vld_in_reset", bigword_vld, 1'b0);
            end else if (bigword_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_vld", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("bigword", bigword, e.data);
                    chk("latency", 64'(cyc), 64'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("missing_vld", 1'b0, 1'b1);
            end
        end
    end

    // Reference: single remembered word per buffer generation.
    int            m_gen  = 0;
    bit            m_vld  = 1'b0;
    logic [AW-1:0] m_addr = '0;

    task automatic drive(input bit rd, input logic [AW-1:0] a, input bit ac, input bit rj,
                         input bit rk);
        bit inv, exp_hit, exp_miss;
        @(posedge clk);
        #1;
        rd_en         = rd;
        word_rd_addra = a;
        acc           = ac;
        rej           = rj;
        rdy_ack       = rk;
        mem_rdy       = 1'($urandom);
        mem_byte_len  = $urandom;
        inv = ac | rj | rk;
        if (inv) m_gen++;
`ifdef PACKMEM_RD_CACHE_EN
        exp_hit = rd && m_vld && (a == m_addr) && !inv;
`else
        exp_hit = 1'b0;
`endif
        exp_miss = rd && !exp_hit;
        #1;
        chk("mem_rd_en", mem_rd_en, exp_miss);
        chk("passthru", {rdy, byte_len, mem_rd_addr, mem_acc, mem_rej, mem_rdy_ack},
            {mem_rdy, mem_byte_len, a, ac, rj, rk});
        if (rd) sb.push_back('{mem_word(a, m_gen), cyc + MEM_LAT});
        if (exp_miss) begin
            m_vld  = 1'b1;
            m_addr = a;
        end else if (inv) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        rd_en         = 1'b1;
        word_rd_addra = 10'h3ff;
        acc           = 1'b0;
        rej           = 1'b0;
        rdy_ack       = 1'b0;
        mem_rdy       = 1'b0;
        mem_byte_len  = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_rd_en", mem_rd_en, 1'b0);
        chk("rst_bigword", bigword, '0);
        chk("rst_bigword_vld", bigword_vld, 1'b0);
        rd_en = 1'b0;
        rst   = 1'b1;

        // Cold miss followed by a hit on the same word.
        drive(1'b1, 10'h010, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 10'h010, 1'b0, 1'b0, 1'b0);
        idle(MEM_LAT + 1);
        // Alternating addresses.
        drive(1'b1, 10'h001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 10'h002, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 10'h001, 1'b0, 1'b0, 1'b0);
        idle(MEM_LAT + 1);
        // Handover between two reads of the same word.
        drive(1'b1, 10'h020, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 10'h020, 1'b0, 1'b0, 1'b0);
        idle(MEM_LAT + 1);
        // Miss coinciding with a handover stays cached.
        drive(1'b1, 10'h030, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 10'h030, 1'b0, 1'b0, 1'b0);
        idle(MEM_LAT + 1);

        // Reset with reads in flight.
        drive(1'b1, 10'h100, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 10'h101, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rd_en = 1'b1;
        sb.delete();
        m_vld = 1'b0;
        #1;
        chk("midrst_vld", bigword_vld, 1'b0);
        chk("midrst_mem_rd_en", mem_rd_en, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rd_en = 1'b0;
        rst   = 1'b1;
        drive(1'b1, 10'h005, 1'b0, 1'b0, 1'b0);
        idle(MEM_LAT + 1);

        // Random traffic over a small address set to get frequent hits.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 10'($urandom_range(0, 7)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0);
        end
        idle(MEM_LAT + 3);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
